// File: rtl/vram_scan_pkg.sv
// Shared types and sizing for the VRAM write-address scan generator.
package vram_scan_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned VRAM_AW      = 19;
    localparam int unsigned POS_W        = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    // Current write position as one registered payload.
    typedef struct packed {
        logic [POS_W-1:0]   hpos;
        logic [POS_W-1:0]   vpos;
        logic [VRAM_AW-1:0] addr;
    } pix_pos_t;

endpackage

// File: rtl/vram_scan_gen_tick_sync.sv
// Two-flop synchroniser for the asynchronous frame tick, followed by a
// rising-edge detector. tick is high for one cycle per low-to-high transition.
module tick_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchroniser chain and edge-detect history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/vram_scan_gen.sv
// VRAM write scan generator: on each frame tick (when enabled) walks every
// pixel of an H_ACTIVE x V_ACTIVE frame, emitting column, line and linear
// address with a write enable. Optional inter-line idle gaps are built when
// VRAM_SCAN_HGAP_EN is defined.
module vram_scan_gen
    import vram_scan_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned HGAP     = 4
) (
    input  logic               clk25M,
    input  logic               reset,
    input  logic               clk60,
    input  logic               en,
    output logic [POS_W-1:0]   whpos,
    output logic [POS_W-1:0]   wvpos,
    output logic [VRAM_AW-1:0] write_vramA,
    output logic               write_ENA,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_ACTIVE - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_ACTIVE - 1);

`ifdef VRAM_SCAN_HGAP_EN
    // HGAP must be at least 1 when gaps are enabled.
    localparam int unsigned    GAP_W    = (HGAP > 1) ? $clog2(HGAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HGAP - 1);

    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
`else
    // Gap length is meaningless without the gap feature.
    logic unused_hgap;
    assign unused_hgap = ^HGAP;
`endif

    logic        tick;
    scan_state_t state_q, state_d;
    pix_pos_t    pos_q, pos_d;
    logic        wen_q, wen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    tick_sync u_tick_sync (
        .clk_i   (clk25M),
        .rst_i   (reset),
        .async_i (clk60),
        .tick    (tick)
    );

    // Next-state, next-position and flag logic.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        wen_d     = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
`ifdef VRAM_SCAN_HGAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        // A tick outside IDLE never restarts the scan, it only flags.
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                pos_d = '0;
                if (tick && en) begin
                    state_d = SCAN;
                    wen_d   = 1'b1;
                end
            end
            SCAN: begin
                wen_d = 1'b1;
                if (pos_q.hpos == H_LAST) begin
                    if (pos_q.vpos == V_LAST) begin
                        state_d = DONE;
                        wen_d   = 1'b0;
                        done_d  = 1'b1;
                        pos_d   = '0;
                    end else begin
                        pos_d.hpos = '0;
                        pos_d.vpos = pos_q.vpos + POS_W'(1);
                        pos_d.addr = pos_q.addr + VRAM_AW'(1);
`ifdef VRAM_SCAN_HGAP_EN
                        state_d   = GAP;
                        wen_d     = 1'b0;
                        gap_cnt_d = '0;
`endif
                    end
                end else begin
                    pos_d.hpos = pos_q.hpos + POS_W'(1);
                    pos_d.addr = pos_q.addr + VRAM_AW'(1);
                end
            end
`ifdef VRAM_SCAN_HGAP_EN
            GAP: begin
                // Position already holds the next line's first pixel.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = SCAN;
                    wen_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                pos_d   = '0;
            end
            default: begin
                state_d = IDLE;
                pos_d   = '0;
            end
        endcase

        busy_d = (state_d == SCAN) || (state_d == GAP);
    end

    // State and output registers.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            wen_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VRAM_SCAN_HGAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            wen_q     <= wen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef VRAM_SCAN_HGAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign whpos       = pos_q.hpos;
    assign wvpos       = pos_q.vpos;
    assign write_vramA = pos_q.addr;
    assign write_ENA   = wen_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_vram_scan_gen.sv
// Directed bench for vram_scan_gen on a reduced 8x4 frame.
module tb_vram_scan_gen;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HG = 4;
    localparam int N  = H * V;

    logic        clk25M = 1'b0;
    logic        reset;
    logic        clk60;
    logic        en;
    logic [9:0]  whpos;
    logic [9:0]  wvpos;
    logic [18:0] write_vramA;
    logic        write_ENA;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    vram_scan_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .HGAP     (HG)
    ) dut (
        .clk25M      (clk25M),
        .reset       (reset),
        .clk60       (clk60),
        .en          (en),
        .whpos       (whpos),
        .wvpos       (wvpos),
        .write_vramA (write_vramA),
        .write_ENA   (write_ENA),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk25M = ~clk25M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25M);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_whpos"}, 32'(whpos), 0);
        chk({tag, "_wvpos"}, 32'(wvpos), 0);
        chk({tag, "_addr"},  32'(write_vramA), 0);
        chk({tag, "_wen"},   32'(write_ENA), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(frame_done), 0);
        chk({tag, "_ovr"},   32'(overrun), 0);
    endtask

    // One-cycle clk60 pulse; returns sampled at the first pixel (edge k+2).
    task automatic start_frame();
        clk60 = 1'b1;
        step();
        chk("start_k_wen", 32'(write_ENA), 0);
        clk60 = 1'b0;
        step();
        chk("start_k1_wen", 32'(write_ENA), 0);
        step();
        chk("start_first_wen", 32'(write_ENA), 1);
        chk("start_first_addr", 32'(write_vramA), 0);
    endtask

    // Walk the frame from pixel p0, checking every cycle up to frame_done.
    task automatic check_frame(input int p0, input int tick_at, input int drop_en_at);
        int p;
        int gaps;
        bit done;
        p    = p0;
        gaps = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (write_ENA) begin
                chk("pix_addr", 32'(write_vramA), p);
                chk("pix_h", 32'(whpos), p % H);
                chk("pix_v", 32'(wvpos), p / H);
                chk("pix_busy", 32'(busy), 1);
                chk("pix_no_done", 32'(frame_done), 0);
                if (p == tick_at)    clk60 = 1'b1;
                if (p == drop_en_at) en = 1'b0;
                p++;
            end else if (frame_done) begin
                chk("done_after_last", p, N);
                chk("done_addr", 32'(write_vramA), 0);
                chk("done_busy", 32'(busy), 0);
                done = 1'b1;
            end else begin
                gaps++;
                chk("gap_at_boundary", p % H, 0);
                chk("gap_addr", 32'(write_vramA), p);
                chk("gap_h", 32'(whpos), 0);
                chk("gap_v", 32'(wvpos), p / H);
                chk("gap_busy", 32'(busy), 1);
            end
            if (!done) step();
        end
        chk("frame_completed", 32'(done), 1);
`ifdef VRAM_SCAN_HGAP_EN
        chk("gap_cycles", gaps, (V - 1) * HG);
`else
        chk("gap_cycles", gaps, 0);
`endif
        step();
        chk("done_pulse_width", 32'(frame_done), 0);
        chk("post_done_wen", 32'(write_ENA), 0);
        chk("post_done_busy", 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        clk60 = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Normal frame.
        en = 1'b1;
        start_frame();
        chk("first_h", 32'(whpos), 0);
        chk("first_v", 32'(wvpos), 0);
        chk("first_busy", 32'(busy), 1);
        check_frame(0, -1, -1);
        chk("frame1_no_overrun", 32'(overrun), 0);

        // Tick with en low: nothing starts.
        en = 1'b0;
        repeat (3) step();
        clk60 = 1'b1;
        repeat (6) begin
            step();
            chk("en0_busy", 32'(busy), 0);
            chk("en0_wen", 32'(write_ENA), 0);
        end
        clk60 = 1'b0;
        repeat (3) step();

        // Second tick mid-scan: no restart, overrun sticks.
        en = 1'b1;
        start_frame();
        check_frame(0, 4, -1);
        chk("overrun_set", 32'(overrun), 1);
        clk60 = 1'b0;
        repeat (3) step();
        chk("overrun_sticky", 32'(overrun), 1);
        reset = 1'b1;
        step();
        chk_all_zero("ovr_reset");
        reset = 1'b0;
        step();

        // Reset mid-frame aborts; restart from address 0 on a fresh tick.
        start_frame();
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 100 && !hit; c++) begin
                if (write_vramA == 19'd10) hit = 1'b1;
                else step();
            end
            chk("reached_addr10", 32'(hit), 1);
        end
        reset = 1'b1;
        step();
        chk_all_zero("mid_reset");
        reset = 1'b0;
        repeat (4) begin
            step();
            chk("post_reset_idle_busy", 32'(busy), 0);
            chk("post_reset_idle_wen", 32'(write_ENA), 0);
        end
        start_frame();
        check_frame(0, -1, -1);

        // en dropped mid-frame: frame completes, no new frame.
        start_frame();
        check_frame(0, -1, 10);
        chk("en_drop_no_overrun", 32'(overrun), 0);
        repeat (3) step();
        clk60 = 1'b1;
        repeat (6) begin
            step();
            chk("en_drop_busy", 32'(busy), 0);
            chk("en_drop_wen", 32'(write_ENA), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
